collisions_ctrl: RTL and testbench

//  Sequencer/arbiter for the 1024x64 collision-table SDPB RAM (write port A, read port B, 1-cycle read).

---
 rtl/collisions_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_collisions_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collisions_ctrl.sv
// collisions_ctrl: sequencer/arbiter for the collision-table simple dual-port RAM.
// The RAM has write port A, read port B and a 1-cycle read.
// - Sweeps the table to zero after reset and on every frame start.
// - OR-accumulates collision masks into table entries (read-modify-write).
// - Shares read port B between those RMW reads and 16-bit CPU word reads.
// A one-deep forward register holds the most recent RMW write. A read of the same
// entry one cycle later takes the new value from it instead of the stale RAM output.
module collisions_ctrl #(
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 64,
  parameter  int WORD_W = 16,
  localparam int WSEL_W = $clog2(DATA_W / WORD_W),
  localparam int CA_W   = ADDR_W + WSEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              busy,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [DATA_W-1:0] set_mask,
  input  logic              cpu_rd_valid,
  output logic              cpu_rd_ready,
  input  logic [CA_W-1:0]   cpu_rd_addr,
  output logic [WORD_W-1:0] cpu_rd_data,
  output logic              cpu_rd_dvalid,
  output logic              bram_cea,
  output logic [ADDR_W-1:0] bram_ada,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_ceb,
  output logic [ADDR_W-1:0] bram_adb,
  output logic              bram_oce,
  input  logic [DATA_W-1:0] bram_dout
);

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = {ADDR_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_rr;

  logic                w_arb_ok;
  logic                w_set_acc;
  logic                w_cpu_acc;
  logic                w_contested;
  logic                w_clr_we;

  logic                r_rmw_v_p1;
  logic [ADDR_W-1:0]   r_rmw_addr_p1;
  logic [DATA_W-1:0]   r_rmw_mask_p1;
  logic                r_rd_v_p1;
  logic [ADDR_W-1:0]   r_rd_addr_p1;
  logic [WSEL_W-1:0]   r_rd_wsel_p1;

  logic                r_fwd_v;
  logic [ADDR_W-1:0]   r_fwd_addr;
  logic [DATA_W-1:0]   r_fwd_data;

  logic [DATA_W-1:0]   w_rmw_src;
  logic [DATA_W-1:0]   w_rmw_merged;
  logic [DATA_W-1:0]   w_rd_src;
  logic [WORD_W-1:0]   w_rd_word;

  logic                r_dvalid_p2;
  logic [WORD_W-1:0]   r_rd_data_p2;

  // Source of a read: the forward register when it holds the entry, else the RAM output.
  function automatic logic [DATA_W-1:0] f_fwd_src(
    input logic              fwd_v,
    input logic [ADDR_W-1:0] fwd_addr,
    input logic [DATA_W-1:0] fwd_data,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] ram_data
  );
    return (fwd_v && (fwd_addr == addr)) ? fwd_data : ram_data;
  endfunction

  // Word wsel of an entry; word 0 is the least significant WORD_W bits.
  function automatic logic [WORD_W-1:0] f_word_sel(
    input logic [DATA_W-1:0] entry,
    input logic [WSEL_W-1:0] wsel
  );
    return entry[wsel*WORD_W +: WORD_W];
  endfunction

  // State register: the sweep always reruns from CLEAR after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  // Next state: a frame start (re)enters CLEAR; the sweep ends after the last entry.
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start)                                     w_state_nxt = S_CLEAR;
    else if (r_state == S_CLEAR && r_clr_cnt == LAST_ENTRY) w_state_nxt = S_RUN;
  end

  // State outputs: busy flags the sweep; no clear write while reset is held.
  always_comb begin
    busy     = (r_state == S_CLEAR);
    w_clr_we = (r_state == S_CLEAR) && !reset;
  end

  // Clear counter: restart at entry 0 on a frame start, advance one entry per CLEAR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_clr_cnt <= '0;
    else if (frame_start)       r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // Port B arbitration: one grant per cycle; a contest goes to set when r_rr is 0.
  always_comb begin
    w_arb_ok     = (r_state == S_RUN) && !frame_start;
    set_ready    = w_arb_ok && (!cpu_rd_valid || !r_rr);
    cpu_rd_ready = w_arb_ok && (!set_valid || r_rr);
    w_set_acc    = set_valid && set_ready;
    w_cpu_acc    = cpu_rd_valid && cpu_rd_ready;
    w_contested  = w_arb_ok && set_valid && cpu_rd_valid;
  end

  // Round-robin bit: flips only when both requesters competed for the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_rr <= 1'b0;
    else if (w_contested) r_rr <= ~r_rr;
  end

  // Port B drive: the read is issued in the acceptance cycle.
  always_comb begin
    bram_ceb = w_set_acc || w_cpu_acc;
    bram_adb = '0;
    if (w_set_acc)      bram_adb = set_addr;
    else if (w_cpu_acc) bram_adb = cpu_rd_addr[CA_W-1:WSEL_W];
  end

  // ---- p0 -> p1: accepted requests wait one cycle for the RAM read data ----

  // p1 valids: reset drops any in-flight RMW or CPU read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rmw_v_p1 <= 1'b0;
      r_rd_v_p1  <= 1'b0;
    end else begin
      r_rmw_v_p1 <= w_set_acc;
      r_rd_v_p1  <= w_cpu_acc;
    end
  end

  // p1 payload: only meaningful alongside its valid, so it is not reset.
  always_ff @(posedge clk) begin
    r_rmw_addr_p1 <= set_addr;
    r_rmw_mask_p1 <= set_mask;
    r_rd_addr_p1  <= cpu_rd_addr[CA_W-1:WSEL_W];
    r_rd_wsel_p1  <= cpu_rd_addr[WSEL_W-1:0];
  end

  // p1 datapath: resolve the hazard, merge the mask and pick the CPU word.
  always_comb begin
    w_rmw_src    = f_fwd_src(r_fwd_v, r_fwd_addr, r_fwd_data, r_rmw_addr_p1, bram_dout);
    w_rmw_merged = w_rmw_src | r_rmw_mask_p1;
    w_rd_src     = f_fwd_src(r_fwd_v, r_fwd_addr, r_fwd_data, r_rd_addr_p1, bram_dout);
    w_rd_word    = f_word_sel(w_rd_src, r_rd_wsel_p1);
  end

  // Port A drive: the clear sweep and RMW writes never share a cycle.
  always_comb begin
    bram_cea = 1'b0;
    bram_ada = '0;
    bram_din = '0;
    if (w_clr_we) begin
      bram_cea = 1'b1;
      bram_ada = r_clr_cnt;
    end else if (r_rmw_v_p1) begin
      bram_cea = 1'b1;
      bram_ada = r_rmw_addr_p1;
      bram_din = w_rmw_merged;
    end
  end

  // Forward valid: set by every RMW write; a frame start discards it since the table is wiped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_fwd_v <= 1'b0;
    else if (frame_start) r_fwd_v <= 1'b0;
    else if (r_rmw_v_p1)  r_fwd_v <= 1'b1;
  end

  // Forward payload: copy of the entry just written on port A.
  always_ff @(posedge clk) begin
    if (r_rmw_v_p1) begin
      r_fwd_addr <= r_rmw_addr_p1;
      r_fwd_data <= w_rmw_merged;
    end
  end

  // ---- p1 -> p2: registered CPU read result ----

  // CPU read output: one-cycle dvalid pulse; the data holds until the next read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvalid_p2  <= 1'b0;
      r_rd_data_p2 <= '0;
    end else begin
      r_dvalid_p2 <= r_rd_v_p1;
      if (r_rd_v_p1) r_rd_data_p2 <= w_rd_word;
    end
  end

  assign cpu_rd_dvalid = r_dvalid_p2;
  assign cpu_rd_data   = r_rd_data_p2;
  assign bram_oce      = 1'b1;

endmodule

// File: tb/tb_collisions_ctrl.sv
// tb_collisions_ctrl: directed and randomized checks of collisions_ctrl.
// Includes a behavioural RAM on the bram_* ports.
// The reference is an abstract table: accepted sets OR into it, and a frame start or reset zeroes it.
// CPU reads snapshot it at acceptance and are due two cycles later.
module tb_collisions_ctrl;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int WW = 16;
  localparam int WS = 2;
  localparam int CW = AW + WS;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          busy;
  logic          set_valid;
  logic          set_ready;
  logic [AW-1:0] set_addr;
  logic [DW-1:0] set_mask;
  logic          cpu_rd_valid;
  logic          cpu_rd_ready;
  logic [CW-1:0] cpu_rd_addr;
  logic [WW-1:0] cpu_rd_data;
  logic          cpu_rd_dvalid;
  logic          bram_cea;
  logic [AW-1:0] bram_ada;
  logic [DW-1:0] bram_din;
  logic          bram_ceb;
  logic [AW-1:0] bram_adb;
  logic          bram_oce;
  logic [DW-1:0] bram_dout;

  always #5 clk = ~clk;

  collisions_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .set_valid(set_valid), .set_ready(set_ready), .set_addr(set_addr), .set_mask(set_mask),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_ready(cpu_rd_ready), .cpu_rd_addr(cpu_rd_addr),
    .cpu_rd_data(cpu_rd_data), .cpu_rd_dvalid(cpu_rd_dvalid),
    .bram_cea(bram_cea), .bram_ada(bram_ada), .bram_din(bram_din),
    .bram_ceb(bram_ceb), .bram_adb(bram_adb), .bram_oce(bram_oce), .bram_dout(bram_dout)
  );

  // Simple dual-port RAM, read-first, 1-cycle read latency.
  logic [DW-1:0] ram [N];
  always @(posedge clk) begin
    if (bram_cea) ram[bram_ada] <= bram_din;
    if (bram_ceb) bram_dout <= ram[bram_adb];
  end

  int            errors = 0;
  int            checks = 0;
  int            cyc_n  = 0;
  int            clear_rem = 0;
  logic [DW-1:0] gold [N];
  logic [WW-1:0] rdq [$];
  int            rd_due [$];
  bit            set_turn = 1'b1;
  bit            prev_set = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  bit            g_acc_set;
  bit            g_acc_cpu;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic drive(input bit sv, input logic [AW-1:0] sa, input logic [DW-1:0] sm,
                       input bit cv, input logic [CW-1:0] ca, input bit fs);
    set_valid = sv; set_addr = sa; set_mask = sm;
    cpu_rd_valid = cv; cpu_rd_addr = ca; frame_start = fs;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic zero_gold();
    foreach (gold[i]) gold[i] = '0;
  endtask

  // One clock cycle: inputs already driven just after the rising edge; checks at the falling edge.
  task automatic step();
    bit            exp_busy, ok, es, ec, exp_dv;
    logic [DW-1:0] ent;
    @(negedge clk);
    exp_busy = (clear_rem > 0);
    chk("busy", busy, exp_busy);
    chk("oce", bram_oce, 1);
    ok = !exp_busy && !frame_start;
    es = 1'b0; ec = 1'b0;
    if (ok) begin
      if (set_valid && cpu_rd_valid) begin
        es = set_turn; ec = !set_turn; set_turn = !set_turn;
      end else begin
        es = set_valid; ec = cpu_rd_valid;
      end
    end else begin
      chk("set_ready_blocked", set_ready, 0);
      chk("cpu_ready_blocked", cpu_rd_ready, 0);
    end
    g_acc_set = set_valid && set_ready;
    g_acc_cpu = cpu_rd_valid && cpu_rd_ready;
    chk("grant_set", g_acc_set, es);
    chk("grant_cpu", g_acc_cpu, ec);
    chk("ceb", bram_ceb, es || ec);
    if (es)      chk("adb_set", bram_adb, set_addr);
    else if (ec) chk("adb_cpu", bram_adb, cpu_rd_addr[CW-1:WS]);
    if (exp_busy) begin
      chk("clr_cea", bram_cea, 1);
      chk("clr_ada", bram_ada, N - clear_rem);
      chk("clr_din", bram_din, 0);
    end else begin
      chk("rmw_cea", bram_cea, prev_set);
      if (prev_set) begin
        chk("rmw_ada", bram_ada, prev_addr);
        chk("rmw_din", bram_din, gold[prev_addr]);
      end
    end
    exp_dv = (rd_due.size() > 0) && (rd_due[0] == cyc_n);
    chk("dvalid", cpu_rd_dvalid, exp_dv);
    if (exp_dv) begin
      void'(rd_due.pop_front());
      chk("rd_data", cpu_rd_data, rdq.pop_front());
    end
    if (es) gold[set_addr] = gold[set_addr] | set_mask;
    if (ec) begin
      ent = gold[cpu_rd_addr[CW-1:WS]];
      rdq.push_back(ent[cpu_rd_addr[WS-1:0]*WW +: WW]);
      rd_due.push_back(cyc_n + 2);
    end
    prev_set  = es;
    prev_addr = set_addr;
    if (frame_start) begin
      zero_gold();
      clear_rem = N;
    end else if (clear_rem > 0) begin
      clear_rem--;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  // Hold reset for n cycles, checking the reset output values; afterwards a full sweep is due.
  task automatic do_reset(input int n);
    idle();
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_cea", bram_cea, 0);
      chk("rst_ceb", bram_ceb, 0);
      chk("rst_dvalid", cpu_rd_dvalid, 0);
      chk("rst_data", cpu_rd_data, 0);
      chk("rst_set_ready", set_ready, 0);
      chk("rst_cpu_ready", cpu_rd_ready, 0);
      chk("rst_oce", bram_oce, 1);
      @(posedge clk); #1;
      cyc_n++;
    end
    reset = 1'b0;
    clear_rem = N;
    prev_set = 1'b0;
    set_turn = 1'b1;
    rdq.delete();
    rd_due.delete();
    zero_gold();
  endtask

  task automatic finish_clear();
    idle();
    while (clear_rem > 0) step();
  endtask

  task automatic ram_zero_check(input string tag);
    int nz = 0;
    foreach (ram[i]) if (ram[i] !== '0) nz++;
    chk(tag, nz, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ns, nc;
    bit            first_set;
    logic [DW-1:0] saved;
    bit            sv, cv, fs;
    logic [AW-1:0] sa;
    logic [CW-1:0] ca;
    logic [DW-1:0] sm;

    // Reset release followed by the full 1024-entry sweep.
    do_reset(3);
    finish_clear();
    idle();
    #1;
    chk("idle_set_ready", set_ready, 1);
    chk("idle_cpu_ready", cpu_rd_ready, 1);
    step();
    ram_zero_check("ram_cleared_after_reset");

    // Back-to-back sets to one entry, then a word read.
    drive(1, 10'd5, 64'h1, 0, '0, 0);   step();
    drive(1, 10'd5, 64'h100, 0, '0, 0); step();
    drive(0, '0, '0, 1, 12'h014, 0);    step();
    idle(); step(); step(); step();
    chk("t2_word", cpu_rd_data, 16'h0101);

    // Top word versus bottom word of an entry.
    drive(1, 10'd7, 64'hFFFF_0000_0000_0000, 0, '0, 0); step();
    drive(0, '0, '0, 1, 12'h01F, 0); step();
    idle(); step();
    chk("t3_word3", cpu_rd_data, 16'hFFFF);
    drive(0, '0, '0, 1, 12'h01C, 0); step();
    idle(); step(); step();
    chk("t3_word0", cpu_rd_data, 16'h0000);

    // Both requesters held high: grants alternate, starting with set.
    ns = 0; nc = 0; first_set = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 10'd9, {$urandom, $urandom}, 1, {10'd9, 2'd1}, 0);
      step();
      if (i == 0) first_set = g_acc_set;
      ns += int'(g_acc_set);
      nc += int'(g_acc_cpu);
    end
    idle(); step(); step(); step();
    chk("t4_first_is_set", first_set, 1);
    chk("t4_set_grants", ns, 4);
    chk("t4_cpu_grants", nc, 4);

    // Random traffic on a few entries to exercise hazards, with rare frame starts.
    for (int i = 0; i < 600; i++) begin
      sv = ($urandom_range(0, 99) < 60);
      cv = ($urandom_range(0, 99) < 50);
      fs = ($urandom_range(0, 299) == 0);
      sa = AW'($urandom_range(0, 7));
      sm = {$urandom, $urandom} & {$urandom, $urandom};
      ca = {AW'($urandom_range(0, 7)), WS'($urandom_range(0, 3))};
      drive(sv, sa, sm, cv, ca, fs);
      step();
    end
    finish_clear();
    idle(); step(); step(); step();
    for (int i = 0; i < 8; i++) chk("rand_ram_vs_model", ram[i], gold[i]);

    // Frame start in the middle of a set stream.
    drive(1, 10'd5, 64'hFFFF, 0, '0, 0); step();
    drive(0, '0, '0, 1, 12'h014, 0);     step();
    idle(); step(); step();
    chk("t5_before", cpu_rd_data, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      drive(1, 10'd5, {$urandom, $urandom}, 0, '0, 0);
      step();
    end
    saved = gold[5];
    drive(1, 10'd5, 64'h1234, 0, '0, 1); step();
    chk("t5_pending_commit", ram[5], saved);
    drive(1, 10'd5, 64'h5678, 0, '0, 0); step();
    finish_clear();
    drive(0, '0, '0, 1, 12'h014, 0); step();
    idle(); step(); step();
    chk("t5_after_clear", cpu_rd_data, 16'h0000);

    // Reset in the middle of an RMW: the write must not land.
    saved = ram[3];
    drive(1, 10'd3, 64'hA5A5, 0, '0, 0); step();
    do_reset(2);
    chk("t6_rmw_dropped", ram[3], saved);
    finish_clear();

    // Reset in the middle of a CPU read: no dvalid afterwards.
    drive(0, '0, '0, 1, 12'h00C, 0); step();
    do_reset(2);
    finish_clear();
    idle(); step(); step();
    ram_zero_check("ram_cleared_after_reset2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
